// File: rtl/pcpi_lut_acc_cop.sv
// PCPI coprocessor: signed coefficient bank plus persistent accumulator driven by 32 +/-1 control bits.
// Define PCPI_LUT_ACC_SAT_EN to saturate the accumulator instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a matching instruction; operands latched on accept
// BUSY  | CALC in progress, BITS_PER_CYCLE control bits per clock
// DONE  | result ready; output registers load ready/wr/rd on leaving
// HOLD  | waiting for the core to drop pcpi_valid
module pcpi_lut_acc_cop #(
    parameter int WIDTH_COEFFICIENT = 22,
    parameter int N_COEF            = 64,
    parameter int BITS_PER_CYCLE    = 4,
    parameter int ACC_WIDTH         = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int IDX_W = $clog2(N_COEF);
    localparam int BIT_W = 6;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(32 - BITS_PER_CYCLE);

`ifdef PCPI_LUT_ACC_SAT_EN
    localparam int GRP_LOG = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1;
    localparam int SUM_W   = ACC_WIDTH + GRP_LOG + WIDTH_COEFFICIENT;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
`else
    localparam int SUM_W = ACC_WIDTH;
`endif

    localparam logic [1:0] OP_CALC  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

    state_t state, state_d;

    logic                         match;
    logic [1:0]                   op_q;
    logic [31:0]                  rs1_q;
    logic [IDX_W-1:0]             rs2_q;
    logic [BIT_W-1:0]             bit_idx;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  next_sum;
    logic signed [SUM_W-1:0]      step_sum;
    logic signed [SUM_W-1:0]      term;
    logic [BIT_W-1:0]             bit_pos;
    logic [IDX_W-1:0]             coef_idx;
    logic signed [WIDTH_COEFFICIENT-1:0] coef [N_COEF];
    logic                         unused_bits;

    assign match = pcpi_valid
                && ((pcpi_insn & 32'h0000707f) == 32'h00002027)
                && (pcpi_insn[31:27] == 5'd0);

    assign unused_bits = &{1'b0, pcpi_insn[24:15], pcpi_insn[11:7],
                           pcpi_rs2[31:WIDTH_COEFFICIENT]};

    // One BUSY step: sum plus the signed terms of this group of control bits.
    always_comb begin
        step_sum = SUM_W'(sum);
        term     = '0;
        bit_pos  = '0;
        coef_idx = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            bit_pos  = bit_idx + BIT_W'(k);
            coef_idx = rs2_q + IDX_W'(bit_pos);
            term     = SUM_W'(coef[coef_idx]);
            step_sum = rs1_q[bit_pos[4:0]] ? (step_sum + term) : (step_sum - term);
        end
`ifdef PCPI_LUT_ACC_SAT_EN
        if (step_sum > SAT_MAX)
            next_sum = ACC_WIDTH'(SAT_MAX);
        else if (step_sum < SAT_MIN)
            next_sum = ACC_WIDTH'(SAT_MIN);
        else
            next_sum = ACC_WIDTH'(step_sum);
`else
        next_sum = step_sum;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (match) state_d = (pcpi_insn[26:25] == OP_CALC) ? BUSY : DONE;
            BUSY: begin
                if (!pcpi_valid)
                    state_d = IDLE;
                else if (bit_idx == LAST_IDX)
                    state_d = DONE;
            end
            DONE: state_d = HOLD;
            HOLD: if (!pcpi_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            bit_idx <= '0;
            acc     <= '0;
            sum     <= '0;
            for (int i = 0; i < N_COEF; i++)
                coef[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        op_q    <= pcpi_insn[26:25];
                        rs1_q   <= pcpi_rs1;
                        rs2_q   <= pcpi_rs2[IDX_W-1:0];
                        sum     <= acc;
                        bit_idx <= '0;
                        if (pcpi_insn[26:25] == OP_LOAD)
                            coef[pcpi_rs1[IDX_W-1:0]] <= pcpi_rs2[WIDTH_COEFFICIENT-1:0];
                        if (pcpi_insn[26:25] == OP_CLEAR)
                            acc <= '0;
                    end
                end
                BUSY: begin
                    // Abort leaves acc alone: sum is only committed on the last group.
                    if (pcpi_valid) begin
                        sum     <= next_sum;
                        bit_idx <= bit_idx + BIT_W'(BITS_PER_CYCLE);
                        if (bit_idx == LAST_IDX)
                            acc <= next_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            pcpi_ready <= (state == DONE);
            pcpi_wr    <= (state == DONE) && (op_q != OP_LOAD);
            pcpi_rd    <= ((state == DONE) && (op_q != OP_LOAD)) ? 32'(acc) : 32'd0;
            pcpi_wait  <= (state == BUSY) || (state == DONE);
        end
    end
endmodule

// File: tb/tb_pcpi_lut_acc_cop.sv
// Self-checking bench for pcpi_lut_acc_cop against a plain-arithmetic accumulator model.
// Build with PCPI_LUT_ACC_SAT_EN defined to check the saturating variant.
module tb_pcpi_lut_acc_cop;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0;
    logic [31:0] pcpi_rs1 = '0;
    logic [31:0] pcpi_rs2 = '0;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int checks = 0;
    int errors = 0;

    longint      coef_m [64];
    logic [31:0] acc_m = '0;

    logic [31:0] r_rd;
    logic        r_wr;
    int          r_lat;

    always #5 clk = ~clk;

    pcpi_lut_acc_cop dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h27};
    endfunction

    function automatic logic [31:0] model_calc(input logic [31:0] rs1, input logic [31:0] rs2);
        longint s;
        int     idx;
        s = longint'($signed(acc_m));
        for (int g = 0; g < 32; g += 4) begin
            for (int j = g; j < g + 4; j++) begin
                idx = int'((rs2 + 32'(j)) % 32'd64);
                s = rs1[j] ? s + coef_m[idx] : s - coef_m[idx];
            end
`ifdef PCPI_LUT_ACC_SAT_EN
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] model_apply(input logic [6:0] f7, input logic [31:0] rs1,
                                                input logic [31:0] rs2);
        case (f7)
            7'h00: acc_m = model_calc(rs1, rs2);
            7'h01: begin
                coef_m[int'(rs1 % 32'd64)] = longint'($signed(rs2[21:0]));
                return 32'd0;
            end
            7'h02: acc_m = 32'd0;
            default: ;
        endcase
        return acc_m;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) coef_m[i] = 0;
        acc_m = '0;
    endfunction

    task automatic run_op(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        pcpi_insn  = enc(f7, 3'b010);
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        pcpi_valid = 1'b1;
        r_lat = -1;
        r_rd  = '0;
        r_wr  = 1'b0;
        for (int c = 0; c < 40 && r_lat < 0; c++) begin
            @(negedge clk);
            if (pcpi_ready) begin
                r_lat = c;
                r_rd  = pcpi_rd;
                r_wr  = pcpi_wr;
            end
        end
        pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (pcpi_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", pcpi_wr); end
        checks++;
        if (pcpi_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pcpi_ready); end
        checks++;
        if (pcpi_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", pcpi_wait); end
        checks++;
        if (pcpi_rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", pcpi_rd); end
        resetn = 1'b1;
        model_reset();
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
        if (r_lat != 1 || r_wr !== 1'b1 || r_rd !== 32'd0) begin
            errors++; $display("FAIL reset_read: lat=%0d wr=%b rd=%h want lat=1 wr=1 rd=0", r_lat, r_wr, r_rd);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            exp = model_apply(7'h01, 32'(i), 32'd1);
            run_op(7'h01, 32'(i), 32'd1);
            checks++;
            if (r_lat != 1 || r_wr !== 1'b0 || r_rd !== exp) begin
                errors++; $display("FAIL load_%0d: lat=%0d wr=%b rd=%h want lat=1 wr=0 rd=0", i, r_lat, r_wr, r_rd);
            end
        end
        exp = model_apply(7'h02, 32'd0, 32'd0);
        run_op(7'h02, 32'd0, 32'd0);
        checks++;
        if (r_lat != 1 || r_wr !== 1'b1 || r_rd !== 32'd0) begin
            errors++; $display("FAIL clear: lat=%0d wr=%b rd=%h want lat=1 wr=1 rd=0", r_lat, r_wr, r_rd);
        end
        exp = model_apply(7'h00, 32'hFFFFFFFF, 32'd0);
        run_op(7'h00, 32'hFFFFFFFF, 32'd0);
        checks++;
        if (r_lat != 9 || r_wr !== 1'b1 || r_rd !== 32'd32) begin
            errors++; $display("FAIL calc_ones: lat=%0d wr=%b rd=%h want lat=9 wr=1 rd=20", r_lat, r_wr, r_rd);
        end
        exp = model_apply(7'h00, 32'h0, 32'd0);
        run_op(7'h00, 32'h0, 32'd0);
        checks++;
        if (r_lat != 9 || r_wr !== 1'b1 || r_rd !== 32'd0) begin
            errors++; $display("FAIL calc_zeros: lat=%0d wr=%b rd=%h want lat=9 wr=1 rd=0", r_lat, r_wr, r_rd);
        end
    endtask

    task automatic test_index_wrap();
        logic [31:0] exp;
        exp = model_apply(7'h01, 32'd63, 32'h003FFFFF);
        run_op(7'h01, 32'd63, 32'h003FFFFF);
        for (int i = 0; i < 31; i++) begin
            exp = model_apply(7'h01, 32'(i), 32'd0);
            run_op(7'h01, 32'(i), 32'd0);
        end
        exp = model_apply(7'h02, 32'd0, 32'd0);
        run_op(7'h02, 32'd0, 32'd0);
        exp = model_apply(7'h00, 32'h00000001, 32'd63);
        run_op(7'h00, 32'h00000001, 32'd63);
        checks++;
        if (r_lat != 9 || r_rd !== 32'hFFFFFFFF || r_rd !== exp) begin
            errors++; $display("FAIL index_wrap: lat=%0d rd=%h want lat=9 rd=ffffffff", r_lat, r_rd);
        end
    endtask

    task automatic test_nomatch();
        logic [31:0] bad_insn [3];
        int bad;
        bad_insn[0] = 32'h00003027;
        bad_insn[1] = enc(7'h04, 3'b010);
        bad_insn[2] = 32'h0000202B;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            pcpi_insn  = bad_insn[n];
            pcpi_rs1   = $urandom;
            pcpi_rs2   = $urandom;
            pcpi_valid = 1'b1;
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0) bad++;
            end
            pcpi_valid = 1'b0;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL nomatch_%h: busy/ready cycles=%0d want 0", bad_insn[n], bad);
            end
        end
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
        if (r_lat != 1 || r_rd !== acc_m) begin
            errors++; $display("FAIL nomatch_acc: lat=%0d rd=%h want lat=1 rd=%h", r_lat, r_rd, acc_m);
        end
    endtask

    task automatic test_random();
        logic [6:0]  f7;
        logic [31:0] a, b, exp;
        int          sel;
        for (int i = 0; i < 64; i++) begin
            a = ($urandom & 32'hFFFFFFC0) | 32'(i);
            b = $urandom;
            exp = model_apply(7'h01, a, b);
            run_op(7'h01, a, b);
        end
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            f7  = (sel < 6) ? 7'h00 : (sel < 8) ? 7'h01 : (sel == 8) ? 7'h02 : 7'h03;
            a   = $urandom;
            b   = $urandom;
            exp = model_apply(f7, a, b);
            run_op(f7, a, b);
            checks++;
            if (r_rd !== exp || r_wr !== (f7 != 7'h01) || r_lat != ((f7 == 7'h00) ? 9 : 1)) begin
                errors++;
                $display("FAIL random_%0d op=%0d: lat=%0d wr=%b rd=%h want rd=%h", i, f7, r_lat, r_wr, r_rd, exp);
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        pcpi_insn  = enc(7'h00, 3'b010);
        pcpi_rs1   = $urandom;
        pcpi_rs2   = $urandom;
        pcpi_valid = 1'b1;
        repeat (4) @(negedge clk);
        pcpi_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (pcpi_ready) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_ready: pulses=%0d want 0", seen); end
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
        if (r_rd !== acc_m) begin errors++; $display("FAIL abort_acc: rd=%h want %h", r_rd, acc_m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp, got;
        int pulses;
        a = $urandom;
        b = $urandom;
        exp = model_apply(7'h00, a, b);
        @(negedge clk);
        pcpi_insn  = enc(7'h00, 3'b010);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        pulses = 0;
        got = '0;
        for (int c = 0; c < 40 && pulses == 0; c++) begin
            @(negedge clk);
            if (pcpi_ready) begin pulses++; got = pcpi_rd; end
        end
        repeat (2) begin
            @(negedge clk);
            if (pcpi_ready) pulses++;
        end
        pcpi_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (pcpi_ready) pulses++;
        end
        checks++;
        if (pulses != 1 || got !== exp) begin
            errors++; $display("FAIL held_valid: pulses=%0d rd=%h want pulses=1 rd=%h", pulses, got, exp);
        end
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
        if (r_rd !== acc_m) begin errors++; $display("FAIL held_valid_acc: rd=%h want %h", r_rd, acc_m); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pcpi_insn  = enc(7'h00, 3'b010);
        pcpi_rs1   = $urandom;
        pcpi_rs2   = $urandom;
        pcpi_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pcpi_wait !== 1'b1) begin errors++; $display("FAIL midcalc_wait: got %b want 1", pcpi_wait); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({pcpi_wr, pcpi_ready, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: wr=%b ready=%b wait=%b rd=%h want all 0", pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd);
        end
        @(negedge clk);
        pcpi_valid = 1'b0;
        resetn = 1'b1;
        model_reset();
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
        if (r_lat != 1 || r_rd !== 32'd0) begin
            errors++; $display("FAIL reset_read_after: lat=%0d rd=%h want lat=1 rd=0", r_lat, r_rd);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp;
        int bad;
        for (int i = 0; i < 32; i++) begin
            exp = model_apply(7'h01, 32'(i), 32'h001FFFFF);
            run_op(7'h01, 32'(i), 32'h001FFFFF);
        end
        exp = model_apply(7'h02, 32'd0, 32'd0);
        run_op(7'h02, 32'd0, 32'd0);
        bad = 0;
        for (int n = 0; n < 2048; n++) begin
            exp = model_apply(7'h00, 32'hFFFFFFFF, 32'd0);
            run_op(7'h00, 32'hFFFFFFFF, 32'd0);
            if (r_rd !== exp || r_lat != 9) begin
                bad++;
                if (bad <= 3) $display("FAIL sat_step_%0d: rd=%h lat=%0d want rd=%h lat=9", n, r_rd, r_lat, exp);
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sat_sequence: bad steps=%0d want 0", bad); end
        run_op(7'h03, 32'd0, 32'd0);
        checks++;
`ifdef PCPI_LUT_ACC_SAT_EN
        if (r_rd !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_final: rd=%h want 7fffffff", r_rd); end
`else
        if (r_rd !== 32'hFFFF0000) begin errors++; $display("FAIL wrap_final: rd=%h want ffff0000", r_rd); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_index_wrap();
        test_nomatch();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcpi_lut_acc_cop.md
Name: pcpi_lut_acc_cop

Overview:
- PCPI responder (coprocessor) serving the picorv32 custom "calculate" instruction family. Opcode 0x27, funct3 = 3'b010.
- Holds a signed coefficient bank and a persistent accumulator.
- Evaluates 32 ±1 control bits against the coefficient bank, BITS_PER_CYCLE bits per clock, and returns the accumulator in rd.
- Sits beside the picorv32 core inside the top level, on the core's pcpi_* signals.

Parameters:
- WIDTH_COEFFICIENT, 22: coefficient width, signed two's complement.
- N_COEF, 64: coefficient bank depth; power of two, at least 32.
- BITS_PER_CYCLE, 4: control bits consumed per BUSY cycle; must divide 32.
- ACC_WIDTH, 32: accumulator and working-sum width.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- pcpi_valid  in  1  core presents an instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  rd write enable, qualified by pcpi_ready
- pcpi_rd  out  32  result
- pcpi_wait  out  1  coprocessor busy; suppresses the core's illegal-insn timeout
- pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Decode:
  - match = pcpi_valid & ((pcpi_insn & 32'hfe00707f) == 32'h00002027 | funct7 in {0x00..0x03}), i.e. opcode 0x27, funct3 2.
  - Any other insn is ignored: no wait, no ready.
- funct7 opcodes:
  - 0x00 CALC.
  - 0x01 LOAD: coef[rs1[log2(N_COEF)-1:0]] <= rs2[WIDTH_COEFFICIENT-1:0].
  - 0x02 CLEAR: acc <= 0.
  - 0x03 READ.
- States: IDLE, BUSY, DONE, HOLD.
- IDLE:
  - On match, latch insn, rs1 and rs2 into local registers.
  - LOAD/CLEAR/READ go to DONE.
  - CALC goes to BUSY: sum <= acc, bit_idx <= 0.
- BUSY:
  - Each cycle processes bits j = bit_idx .. bit_idx+BITS_PER_CYCLE-1 of latched rs1.
  - Term j = coef[(rs2 + j) mod N_COEF], sign-extended to ACC_WIDTH; add it if bit j = 1, subtract it if bit j = 0.
  - sum <= sum + Σ terms.
  - bit_idx advances by BITS_PER_CYCLE. After bit 31 has been consumed, go to DONE and commit acc <= sum.
- DONE (one cycle):
  - pcpi_ready = 1.
  - CALC, CLEAR, READ: pcpi_wr = 1, pcpi_rd = acc (new value; CLEAR returns 0).
  - LOAD: pcpi_wr = 0, pcpi_rd = 0.
  - Next state is HOLD.
- HOLD: wait until pcpi_valid == 0, then go to IDLE. This prevents re-triggering on the core's trailing valid.
- pcpi_wait = 1 in BUSY and DONE; 0 otherwise.
- All outputs are registered.
- Latency, counting the match-sampling edge as cycle 0:
  - LOAD/CLEAR/READ: ready in cycle 1.
  - CALC: ready in cycle 32/BITS_PER_CYCLE + 1, i.e. 9 at default.
- Abort: pcpi_valid falling in BUSY returns the block to IDLE. No ready is issued and acc is unchanged, since sum is never committed.
- Arithmetic: wrap-around two's complement at ACC_WIDTH unless the optional feature is enabled. pcpi_rd = acc sign-extended or truncated to 32 bits.
- Reset (asynchronous, any state, including mid-CALC):
  - State to IDLE.
  - acc, sum, bit_idx, all coef entries = 0.
  - pcpi_wr, pcpi_ready, pcpi_wait = 0; pcpi_rd = 0.
- Simultaneous events:
  - A match arriving while not in IDLE is not accepted. The core holds valid until ready, so this never happens in normal operation.
  - LOAD to the index a CALC would read cannot overlap, because ops are serialized.

Optional Feature:
- Macro: PCPI_LUT_ACC_SAT_EN.
- Defined: every BUSY update clamps sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Clamping is per cycle, on the full-precision cycle total, computed with ACC_WIDTH+log2(BITS_PER_CYCLE)+WIDTH_COEFFICIENT guard bits.
- Undefined: plain modular wrap, no guard logic.

Test Plan:
- Basic CALC: LOAD coef[i]=1 for i=0..31; CLEAR; CALC rs1=0xFFFFFFFF, rs2=0 -> ready 9 cycles after accept, wr=1, rd=32. Repeat with rs1=0x00000000 -> rd=0 (acc 32 - 32).
- Sign extension and index wrap: LOAD coef[63]=0x3FFFFF (-1), coef[0..30]=0; CALC rs1=0x00000001, rs2=63 -> contribution of -1 for bit 0; rd=0xFFFFFFFF, after the preceding CLEAR.
- Non-matching insn: insn=0x02002027 (funct7=1 variant allowed) vs 0x00003027 (funct3=3) -> the funct3=3 case gives no wait and no ready for 20 cycles; acc unchanged.
- Abort and reset: drop pcpi_valid at BUSY cycle 3 -> no ready, READ returns the prior acc. Assert resetn=0 mid-CALC -> outputs 0 immediately, READ afterwards = 0.
- Handshake: hold pcpi_valid 1 for 2 cycles after ready -> exactly one ready pulse, acc updated once.
- Saturation (PCPI_LUT_ACC_SAT_EN): coef[0..31]=0x1FFFFF; CALC rs1=0xFFFFFFFF repeated 2048 times -> rd saturates at 0x7FFFFFFF. Without the macro the same sequence wraps negative.
